mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/pycpu_bus_pkg.sv | 24 ++
 rtl/bus_priority_picker.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pycpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pycpu_bus_pkg
//  Description : Shared constants for the memory bus arbiter: state encoding,
//                requester indices and parameter defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package pycpu_bus_pkg;

    localparam int unsigned WAIT_CYCLES_DEFAULT  = 1;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned REQ_INT   = 0;
    localparam int unsigned REQ_DATA  = 1;
    localparam int unsigned REQ_FETCH = 2;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_XFER = 2'd3;

endpackage
`default_nettype wire

// File: rtl/bus_priority_picker.sv
`default_nettype none
// ============================================================================
//  Module      : bus_priority_picker
//  Description : Combinational one-hot winner select; fixed priority
//                int > data > fetch unless fetch is flagged as starved.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_priority_picker
    import pycpu_bus_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_starve,
    output logic [NUM_REQ-1:0] o_gnt
);

    always_comb begin
        o_gnt = '0;
        if (i_starve && i_req[REQ_FETCH]) begin
            o_gnt[REQ_FETCH] = 1'b1;
        end else if (i_req[REQ_INT]) begin
            o_gnt[REQ_INT] = 1'b1;
        end else if (i_req[REQ_DATA]) begin
            o_gnt[REQ_DATA] = 1'b1;
        end else if (i_req[REQ_FETCH]) begin
            o_gnt[REQ_FETCH] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Three-requester memory bus arbiter with wait states, fetch
//                anti-starvation and locked back-to-back (hold) transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter
    import pycpu_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES  = WAIT_CYCLES_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_we,
    input  logic [NUM_REQ-1:0] i_hold,
    input  logic [15:0]        i_addr0,
    input  logic [15:0]        i_addr1,
    input  logic [15:0]        i_addr2,
    input  logic [15:0]        i_wdata0,
    input  logic [15:0]        i_wdata1,
    input  logic [15:0]        i_wdata2,
    input  logic [15:0]        i_rdata,
    input  logic               i_ext_lock,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [NUM_REQ-1:0] o_ack,
    output logic [15:0]        o_rdata,
    output logic [15:0]        o_addr,
    output logic [15:0]        o_wdata,
    output logic               o_rw,
    output logic               o_lock_io,
    output logic               o_busy
);

    localparam logic [2:0] c_WAIT_LOAD  = 3'(WAIT_CYCLES);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [NUM_REQ-1:0] r_gnt;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rdata;
    logic               r_we;
    logic [2:0]         r_wait_cnt;
    logic [3:0]         r_starve_cnt;

    logic               w_starve;
    logic [NUM_REQ-1:0] w_pick;
    logic               w_arb;
    logic               w_relock;
    logic [NUM_REQ-1:0] w_sel;
    logic [15:0]        w_sel_addr;
    logic [15:0]        w_sel_wdata;
    logic               w_sel_we;
    logic               w_busy;

    assign w_starve = (r_starve_cnt == c_STARVE_MAX);
    assign w_arb    = (r_state == c_ST_IDLE) && (|i_req) && !i_ext_lock;
    // A held owner keeps the bus: relatch its inputs without arbitration.
    assign w_relock = (r_state == c_ST_XFER) && (|(r_gnt & i_hold & i_req));
    assign w_sel    = w_relock ? r_gnt : w_pick;

    bus_priority_picker u_picker (
        .i_req    (i_req),
        .i_starve (w_starve),
        .o_gnt    (w_pick)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        if (w_sel[REQ_INT]) begin
            w_sel_addr  = i_addr0;
            w_sel_wdata = i_wdata0;
            w_sel_we    = i_we[REQ_INT];
        end else if (w_sel[REQ_DATA]) begin
            w_sel_addr  = i_addr1;
            w_sel_wdata = i_wdata1;
            w_sel_we    = i_we[REQ_DATA];
        end else if (w_sel[REQ_FETCH]) begin
            w_sel_addr  = i_addr2;
            w_sel_wdata = i_wdata2;
            w_sel_we    = i_we[REQ_FETCH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_arb) w_state_next = c_ST_ADDR;
            c_ST_ADDR: w_state_next = (c_WAIT_LOAD == 3'd0) ? c_ST_XFER : c_ST_WAIT;
            c_ST_WAIT: if (r_wait_cnt <= 3'd1) w_state_next = c_ST_XFER;
            c_ST_XFER: w_state_next = w_relock ? c_ST_ADDR : c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_we         <= 1'b0;
            r_wait_cnt   <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_arb) begin
                        r_gnt   <= w_pick;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_we    <= w_sel_we;
                    end
                    // Only grants made while fetch is waiting count toward starvation.
                    if (!i_req[REQ_FETCH]) begin
                        r_starve_cnt <= '0;
                    end else if (w_arb) begin
                        if (w_pick[REQ_FETCH]) begin
                            r_starve_cnt <= '0;
                        end else if (!w_starve) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end
                c_ST_ADDR: r_wait_cnt <= c_WAIT_LOAD;
                c_ST_WAIT: r_wait_cnt <= r_wait_cnt - 3'd1;
                c_ST_XFER: begin
                    if (!r_we) begin
                        r_rdata <= i_rdata;
                    end
                    if (w_relock) begin
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_we    <= w_sel_we;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                default: r_gnt <= '0;
            endcase
        end
    end

    assign w_busy = (r_state != c_ST_IDLE);

    // Read data passes straight through in the ack cycle, then is held.
    always_comb begin
        o_gnt     = r_gnt;
        o_busy    = w_busy;
        o_lock_io = w_busy;
        o_ack     = (r_state == c_ST_XFER) ? r_gnt : '0;
        o_addr    = w_busy ? r_addr : '0;
        o_wdata   = w_busy ? r_wdata : '0;
        o_rw      = w_busy & r_we;
        o_rdata   = ((r_state == c_ST_XFER) && !r_we) ? i_rdata : r_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench: transaction-level reference model plus
//                directed scenarios with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int W  = 1;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  i_req = '0, i_we = '0, i_hold = '0;
    logic [15:0] i_addr0 = '0, i_addr1 = '0, i_addr2 = '0;
    logic [15:0] i_wdata0 = '0, i_wdata1 = '0, i_wdata2 = '0;
    logic [15:0] i_rdata = '0;
    logic        i_ext_lock = 1'b0;
    logic [2:0]  o_gnt, o_ack;
    logic [15:0] o_rdata, o_addr, o_wdata;
    logic        o_rw, o_lock_io, o_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_hold(i_hold),
        .i_addr0(i_addr0), .i_addr1(i_addr1), .i_addr2(i_addr2),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .i_wdata2(i_wdata2),
        .i_rdata(i_rdata), .i_ext_lock(i_ext_lock),
        .o_gnt(o_gnt), .o_ack(o_ack), .o_rdata(o_rdata), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_rw(o_rw), .o_lock_io(o_lock_io), .o_busy(o_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [56:0] all_outs();
        return {o_gnt, o_ack, o_rdata, o_addr, o_wdata, o_rw, o_lock_io, o_busy};
    endfunction

    // Transaction-level reference: owner, cycles left until its ack, latched request.
    int          m_owner = -1;
    int          m_left  = 0;
    int          m_starve = 0;
    bit          m_init  = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic        m_we = 1'b0;

    task automatic m_latch(input int who);
        case (who)
            0: begin m_addr = i_addr0; m_wdata = i_wdata0; end
            1: begin m_addr = i_addr1; m_wdata = i_wdata1; end
            default: begin m_addr = i_addr2; m_wdata = i_wdata2; end
        endcase
        m_we = i_we[who];
    endtask

    initial begin
        logic [2:0]  e_gnt, e_ack;
        logic        e_busy;
        int          win;
        forever begin
            @(negedge clk);
            if (m_init) begin
                e_busy = (m_owner >= 0);
                e_gnt  = e_busy ? (3'b001 << m_owner) : 3'b000;
                e_ack  = (e_busy && m_left == 0) ? e_gnt : 3'b000;
                chk("m_gnt", o_gnt, e_gnt);
                chk("m_ack", o_ack, e_ack);
                chk("m_busy", o_busy, e_busy);
                chk("m_lock_io", o_lock_io, e_busy);
                chk("m_addr", o_addr, e_busy ? m_addr : 16'h0);
                chk("m_wdata", o_wdata, e_busy ? m_wdata : 16'h0);
                chk("m_rw", o_rw, e_busy & m_we);
                chk("m_rdata", o_rdata, (e_ack != 0 && !m_we) ? i_rdata : m_rdata);
            end
            if (rst) begin
                m_init = 1'b1; m_owner = -1; m_left = 0; m_rdata = '0; m_starve = 0;
            end else if (m_owner < 0) begin
                if (i_req != 3'b000 && !i_ext_lock) begin
                    if (m_starve == SL && i_req[2]) win = 2;
                    else if (i_req[0]) win = 0;
                    else if (i_req[1]) win = 1;
                    else win = 2;
                    m_latch(win);
                    m_owner = win;
                    m_left  = W + 1;
                    if (!i_req[2] || win == 2) m_starve = 0;
                    else if (m_starve < SL) m_starve = m_starve + 1;
                end else if (!i_req[2]) begin
                    m_starve = 0;
                end
            end else if (m_left == 0) begin
                if (!m_we) m_rdata = i_rdata;
                if (i_hold[m_owner] && i_req[m_owner]) begin
                    m_latch(m_owner);
                    m_left = W + 1;
                end else begin
                    m_owner = -1;
                end
            end else begin
                m_left = m_left - 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] order [3];
        logic [2:0] clr;
        int nacks, fetch_at, n_ack1, found;
        bit saw_int;

        // Reset state
        repeat (3) next_cycle();
        @(negedge clk);
        chk("reset_outputs", all_outs(), 57'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single fetch read: addr from N+1, ack and data at N+3
        i_addr2 = 16'h1234; i_we = 3'b000; i_rdata = 16'hBEEF; i_req = 3'b100;
        @(negedge clk); chk("t1_idle_gnt", o_gnt, 3'b000);
        next_cycle(); i_req = 3'b000; i_addr2 = 16'hFFFF;
        @(negedge clk);
        chk("t1_addr", o_addr, 16'h1234); chk("t1_gnt", o_gnt, 3'b100); chk("t1_noack", o_ack, 3'b000);
        next_cycle();
        @(negedge clk); chk("t1_wait_noack", o_ack, 3'b000);
        next_cycle();
        @(negedge clk); chk("t1_ack", o_ack, 3'b100); chk("t1_rdata", o_rdata, 16'hBEEF);
        next_cycle(); i_rdata = 16'h1111;
        @(negedge clk);
        chk("t1_idle_after", o_gnt, 3'b000); chk("t1_rdata_held", o_rdata, 16'hBEEF);
        chk("t1_addr_idle", o_addr, 16'h0);
        next_cycle();

        // Three simultaneous requests granted in priority order
        i_addr0 = 16'h0100; i_addr1 = 16'h0200; i_addr2 = 16'h0300; i_rdata = 16'h5A5A;
        i_req = 3'b111; clr = '0; nacks = 0;
        for (int c = 0; c < 60 && nacks < 3; c++) begin
            @(negedge clk);
            if (o_ack != 3'b000) begin order[nacks] = o_ack; nacks++; clr = o_ack; end
            @(posedge clk); #1;
            i_req = i_req & ~clr; clr = '0;
        end
        chk("t2_nacks", nacks, 3);
        chk("t2_first", order[0], 3'b001);
        chk("t2_second", order[1], 3'b010);
        chk("t2_third", order[2], 3'b100);
        i_req = 3'b000;
        next_cycle();

        // Starvation: fetch wins on the 5th arbitration, then counter cleared
        i_req = 3'b110; nacks = 0; fetch_at = 0;
        for (int c = 0; c < 200 && fetch_at == 0; c++) begin
            @(negedge clk);
            if (o_ack != 3'b000) begin nacks++; if (o_ack == 3'b100) fetch_at = nacks; end
            next_cycle();
        end
        chk("t3_fetch_slot", fetch_at, 5);
        found = 0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            @(negedge clk);
            if (o_ack != 3'b000) begin found = 1; chk("t3_after_fetch", o_ack, 3'b010); end
            next_cycle();
        end
        chk("t3_after_seen", found, 1);
        i_req = 3'b000;
        next_cycle();

        // Held data writes: three locked transfers, interrupt waits
        i_we = 3'b010; i_hold = 3'b010; i_addr1 = 16'h2000; i_wdata1 = 16'h00A1;
        i_req = 3'b010; n_ack1 = 0; saw_int = 1'b0;
        for (int c = 0; c < 80 && !saw_int; c++) begin
            next_cycle();
            i_addr1 = i_addr1 + 16'd1; i_wdata1 = i_wdata1 + 16'd3;
            if (n_ack1 >= 1) i_req[0] = 1'b1;
            if (n_ack1 >= 2) i_hold[1] = 1'b0;
            if (n_ack1 >= 3) i_req[1] = 1'b0;
            @(negedge clk);
            if (n_ack1 < 3) begin
                chk("t4_hold_gnt", o_gnt, 3'b010); chk("t4_hold_lock", o_lock_io, 1'b1);
            end
            if (o_ack == 3'b010) n_ack1++;
            if (o_ack == 3'b001) begin saw_int = 1'b1; chk("t4_acks_before_int", n_ack1, 3); end
        end
        chk("t4_int_seen", saw_int, 1'b1);
        next_cycle();
        i_req = 3'b000; i_hold = 3'b000; i_we = 3'b000;
        next_cycle();

        // External lock blocks arbitration; release grants next cycle
        i_ext_lock = 1'b1; i_req = 3'b010; i_rdata = 16'h7E57;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("t5_locked_gnt", o_gnt, 3'b000);
            next_cycle();
        end
        i_ext_lock = 1'b0;
        next_cycle();
        @(negedge clk); chk("t5_release_gnt", o_gnt, 3'b010);
        next_cycle(); i_ext_lock = 1'b1;
        found = 0;
        for (int c = 0; c < 10 && found == 0; c++) begin
            @(negedge clk);
            if (o_ack == 3'b010) found = 1;
            next_cycle();
        end
        chk("t5_ack_despite_lock", found, 1);
        i_req = 3'b000; i_ext_lock = 1'b0;
        next_cycle();

        // Reset in WAIT aborts with no ack
        i_addr0 = 16'h0C0C; i_req = 3'b001;
        next_cycle(); i_req = 3'b000;
        next_cycle(); rst = 1'b1;
        @(negedge clk); chk("t6_busy_wait", o_busy, 1'b1); chk("t6_noack_wait", o_ack, 3'b000);
        next_cycle();
        @(negedge clk); chk("t6_after_rst", all_outs(), 57'h0);
        next_cycle(); rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("t6_no_late_ack", o_ack, 3'b000);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
